// File: rtl/write_lane_pkg.sv
// Shared types and lookups for write_lane_manager; the CRC state exists only when WR_LANE_CRC_EN is defined.
package write_lane_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREAMBLE  = 3'd1,
    ST_DATA      = 3'd2,
`ifdef WR_LANE_CRC_EN
    ST_CRC       = 3'd3,
`endif
    ST_POSTAMBLE = 3'd4
  } wl_state_e;

  typedef enum logic [1:0] {
    BL_16     = 2'b00,
    BL_BC8    = 2'b01,
    BL_32     = 2'b10,
    BL_16_ALT = 2'b11
  } burst_len_e;

  localparam logic [1:0] DQS_DATA = 2'b10;
  localparam int         CNT_W    = 5;

  typedef struct packed {
    logic [2:0] pre;
    logic [1:0] post;
    logic [1:0] bl;
    logic [7:0] pre_pat;
    logic [3:0] post_pat;
    logic       crc;
  } wr_cfg_t;

  function automatic logic [5:0] burst_cycles(input logic [1:0] bl);
    case (burst_len_e'(bl))
      BL_BC8:  return 6'd8;
      BL_32:   return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/wr_dqs_gen.sv
// Registered DQS strobe generator: picks the per-cycle strobe pair from the
// upcoming state and remaining-cycle count, then replicates it on every lane.
module wr_dqs_gen
  import write_lane_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  wl_state_e              i_state,
  input  logic [1:0]             i_rem,
  input  logic [1:0]             i_post,
  input  logic [7:0]             i_pre_pattern,
  input  logic [3:0]             i_post_pattern,
  output logic [2*NUM_LANES-1:0] o_DQS,
  output logic                   o_DQS_valid
);

  logic [1:0] pair_d;
  logic       valid_d;
  logic       post_bit;
  logic [2*NUM_LANES-1:0] dqs_q;
  logic       valid_q;

  // A 3-cycle postamble plays the 2-entry pattern first, then drives 00.
  assign post_bit = (i_post == 2'd3) ? (i_rem == 2'd2) : i_rem[0];

  always_comb begin
    pair_d  = 2'b00;
    valid_d = 1'b0;
    case (i_state)
      ST_PREAMBLE: begin
        pair_d  = i_pre_pattern[{i_rem, 1'b0} +: 2];
        valid_d = 1'b1;
      end
      ST_DATA: begin
        pair_d  = DQS_DATA;
        valid_d = 1'b1;
      end
`ifdef WR_LANE_CRC_EN
      ST_CRC: begin
        pair_d  = DQS_DATA;
        valid_d = 1'b1;
      end
`endif
      ST_POSTAMBLE: begin
        valid_d = 1'b1;
        if (!(i_post == 2'd3 && i_rem == 2'd0)) begin
          pair_d = i_post_pattern[{post_bit, 1'b0} +: 2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dqs_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dqs_q   <= {NUM_LANES{pair_d}};
      valid_q <= valid_d;
    end
  end

  assign o_DQS       = dqs_q;
  assign o_DQS_valid = valid_q;

endmodule

// File: rtl/write_lane_manager.sv
// Write lane sequencer: preamble, data beats, optional CRC byte (WR_LANE_CRC_EN), postamble.
// States: IDLE no write | PREAMBLE strobe lead-in | DATA beats | CRC crc byte | POSTAMBLE strobe tail
module write_lane_manager
  import write_lane_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int MAX_PRE   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_wr_en,
  input  logic                   i_phy_crc_mode,
  input  logic                   i_DRAM_crc_en,
  input  logic [2:0]             i_precycle,
  input  logic [1:0]             i_postcycle,
  input  logic [1:0]             i_burstlength,
  input  logic [7:0]             i_pre_pattern,
  input  logic [3:0]             i_post_pattern,
  input  logic [8*NUM_LANES-1:0] i_Wr_data,
  input  logic [NUM_LANES-1:0]   i_Wr_datamask,
  input  logic [8*NUM_LANES-1:0] i_crc_code,
  output logic [8*NUM_LANES-1:0] o_DQ,
  output logic                   o_DQ_valid,
  output logic [NUM_LANES-1:0]   o_DM,
  output logic [2*NUM_LANES-1:0] o_DQS,
  output logic                   o_DQS_valid,
  output logic [8*NUM_LANES-1:0] o_crc_data,
  output logic                   o_crc_enable,
  output logic                   o_data_req,
  output logic                   o_busy,
  output logic                   o_wr_err
);

  localparam logic [2:0] MAX_PRE_L = 3'(MAX_PRE);

  wl_state_e              state_q, state_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  wr_cfg_t                cfg_q, cfg_d, pcfg_q, pcfg_d, live_cfg, start_cfg;
  logic                   pend_q, pend_d;
  logic                   wr_take, burst_done, consume, err_d;

  logic [8*NUM_LANES-1:0] dq_d, dq_q, crcd_d, crcd_q;
  logic [NUM_LANES-1:0]   dm_d, dm_q;
  logic                   dqv_d, dqv_q, crce_d, crce_q, req_d, req_q, busy_d, busy_q, err_q;

  function automatic logic [CNT_W-1:0] pre_last(input logic [2:0] pre);
    logic [2:0] p;
    p = (pre == 3'd0) ? 3'd1 : ((pre > MAX_PRE_L) ? MAX_PRE_L : pre);
    return {2'b00, p - 3'd1};
  endfunction

  function automatic logic [CNT_W-1:0] post_last(input logic [1:0] post);
    return (post == 2'd0) ? '0 : {3'b000, post - 2'd1};
  endfunction

  function automatic logic [CNT_W-1:0] beat_last(input logic [1:0] bl);
    return CNT_W'(burst_cycles(bl) - 6'd1);
  endfunction

  always_comb begin
    live_cfg.pre      = i_precycle;
    live_cfg.post     = i_postcycle;
    live_cfg.bl       = i_burstlength;
    live_cfg.pre_pat  = i_pre_pattern;
    live_cfg.post_pat = i_post_pattern;
`ifdef WR_LANE_CRC_EN
    live_cfg.crc      = i_phy_crc_mode & i_DRAM_crc_en;
`else
    live_cfg.crc      = 1'b0;
`endif
  end

`ifndef WR_LANE_CRC_EN
  logic unused_crc;
  assign unused_crc = ^{i_crc_code, i_phy_crc_mode, i_DRAM_crc_en};
`endif

  // Counters run down to zero; a command waiting in the slot (or arriving now)
  // may start as soon as the data/CRC phase is over.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cfg_d      = cfg_q;
    pend_d     = pend_q;
    pcfg_d     = pcfg_q;
    err_d      = 1'b0;
    burst_done = 1'b0;
    consume    = 1'b0;
    start_cfg  = live_cfg;
    wr_take    = i_enable && i_wr_en && (state_q != ST_IDLE);

    if (!i_enable) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_wr_en) begin
            state_d = ST_PREAMBLE;
            cfg_d   = live_cfg;
            rem_d   = pre_last(live_cfg.pre);
          end
        end
        ST_PREAMBLE: begin
          if (rem_q == '0) begin
            state_d = ST_DATA;
            rem_d   = beat_last(cfg_q.bl);
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end else
`ifdef WR_LANE_CRC_EN
          if (cfg_q.crc) begin
            state_d = ST_CRC;
            rem_d   = '0;
          end else
`endif
          begin
            burst_done = 1'b1;
            state_d    = ST_POSTAMBLE;
            rem_d      = post_last(cfg_q.post);
          end
        end
`ifdef WR_LANE_CRC_EN
        ST_CRC: begin
          burst_done = 1'b1;
          state_d    = ST_POSTAMBLE;
          rem_d      = post_last(cfg_q.post);
        end
`endif
        ST_POSTAMBLE: begin
          burst_done = 1'b1;
          if (rem_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (burst_done && (pend_q || wr_take)) begin
        consume   = 1'b1;
        start_cfg = pend_q ? pcfg_q : live_cfg;
        state_d   = ST_PREAMBLE;
        cfg_d     = start_cfg;
        rem_d     = pre_last(start_cfg.pre);
      end

      // The slot frees up in the same cycle it is consumed, so a new command can refill it.
      if (consume) begin
        pend_d = pend_q && wr_take;
        if (pend_q && wr_take) pcfg_d = live_cfg;
      end else if (wr_take) begin
        if (pend_q) begin
          err_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          pcfg_d = live_cfg;
        end
      end
    end
  end

  always_comb begin
    dq_d   = '0;
    dm_d   = '0;
    dqv_d  = 1'b0;
    crcd_d = '0;
    crce_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    req_d  = ((state_d == ST_PREAMBLE) && (rem_d == '0)) ||
             ((state_d == ST_DATA) && (rem_d != '0));
    case (state_d)
      ST_DATA: begin
        dq_d  = i_Wr_data;
        dm_d  = i_Wr_datamask;
        dqv_d = 1'b1;
`ifdef WR_LANE_CRC_EN
        if (cfg_d.crc) begin
          crce_d = 1'b1;
          crcd_d = i_Wr_data;
        end
`endif
      end
`ifdef WR_LANE_CRC_EN
      ST_CRC: begin
        dq_d  = i_crc_code;
        dqv_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cfg_q   <= '0;
      pcfg_q  <= '0;
      pend_q  <= 1'b0;
      dq_q    <= '0;
      dm_q    <= '0;
      dqv_q   <= 1'b0;
      crcd_q  <= '0;
      crce_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cfg_q   <= cfg_d;
      pcfg_q  <= pcfg_d;
      pend_q  <= pend_d;
      dq_q    <= dq_d;
      dm_q    <= dm_d;
      dqv_q   <= dqv_d;
      crcd_q  <= crcd_d;
      crce_q  <= crce_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  wr_dqs_gen #(.NUM_LANES(NUM_LANES)) u_dqs_gen (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_state        (state_d),
    .i_rem          (rem_d[1:0]),
    .i_post         (cfg_d.post),
    .i_pre_pattern  (cfg_d.pre_pat),
    .i_post_pattern (cfg_d.post_pat),
    .o_DQS          (o_DQS),
    .o_DQS_valid    (o_DQS_valid)
  );

  assign o_DQ         = dq_q;
  assign o_DM         = dm_q;
  assign o_DQ_valid   = dqv_q;
  assign o_crc_data   = crcd_q;
  assign o_crc_enable = crce_q;
  assign o_data_req   = req_q;
  assign o_busy       = busy_q;
  assign o_wr_err     = err_q;

endmodule

// File: tb/tb_write_lane_manager.sv
// Randomized bench for write_lane_manager against a frame-queue reference model.
module tb_write_lane_manager;

  localparam int NL   = 2;
  localparam int MAXP = 4;
`ifdef WR_LANE_CRC_EN
  localparam bit CRC_BUILT = 1'b1;
`else
  localparam bit CRC_BUILT = 1'b0;
`endif
  localparam int F_PRE  = 0;
  localparam int F_DATA = 1;
  localparam int F_CRC  = 2;
  localparam int F_POST = 3;

  logic clk = 1'b0;
  logic rst_n, enable, wr_en, phy_crc, dram_crc;
  logic [2:0]  precycle;
  logic [1:0]  postcycle, blen;
  logic [7:0]  pre_pat;
  logic [3:0]  post_pat;
  logic [15:0] wdata, crc_code;
  logic [1:0]  wdm;

  logic [15:0] o_DQ, o_crc_data;
  logic [1:0]  o_DM;
  logic [3:0]  o_DQS;
  logic o_DQ_valid, o_DQS_valid, o_crc_enable, o_data_req, o_busy, o_wr_err;

  write_lane_manager #(.NUM_LANES(NL), .MAX_PRE(MAXP)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_enable(enable), .i_wr_en(wr_en),
    .i_phy_crc_mode(phy_crc), .i_DRAM_crc_en(dram_crc),
    .i_precycle(precycle), .i_postcycle(postcycle), .i_burstlength(blen),
    .i_pre_pattern(pre_pat), .i_post_pattern(post_pat),
    .i_Wr_data(wdata), .i_Wr_datamask(wdm), .i_crc_code(crc_code),
    .o_DQ(o_DQ), .o_DQ_valid(o_DQ_valid), .o_DM(o_DM),
    .o_DQS(o_DQS), .o_DQS_valid(o_DQS_valid),
    .o_crc_data(o_crc_data), .o_crc_enable(o_crc_enable),
    .o_data_req(o_data_req), .o_busy(o_busy), .o_wr_err(o_wr_err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int dqs; bit crc; } frame_t;
  typedef struct { int pre; int post; int bl; int pre_pat; int post_pat; bit crc; } mcfg_t;

  frame_t sched[$];
  mcfg_t  pend_cfg;
  bit     pend = 1'b0;
  bit     err_exp = 1'b0;
  int     last_data = 0, last_dm = 0, last_crc = 0;
  int     n_total = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic mcfg_t live();
    mcfg_t c;
    c.pre = int'(precycle); c.post = int'(postcycle); c.bl = int'(blen);
    c.pre_pat = int'(pre_pat); c.post_pat = int'(post_pat);
    c.crc = phy_crc && dram_crc;
    return c;
  endfunction

  // Expands one write command into its per-cycle frames.
  task automatic launch(input mcfg_t c);
    int p, q, b, qe;
    frame_t f;
    bit with_crc;
    with_crc = c.crc && CRC_BUILT;
    p  = (c.pre < 1) ? 1 : ((c.pre > MAXP) ? MAXP : c.pre);
    b  = (c.bl == 1) ? 8 : ((c.bl == 2) ? 32 : 16);
    q  = (c.post < 1) ? 1 : c.post;
    qe = (q > 2) ? 2 : q;
    sched.delete();
    for (int k = 0; k < p; k++) begin
      f.kind = F_PRE; f.dqs = (c.pre_pat >> (2 * (p - 1 - k))) & 3; f.crc = 1'b0;
      sched.push_back(f);
    end
    for (int k = 0; k < b; k++) begin
      f.kind = F_DATA; f.dqs = 2; f.crc = with_crc;
      sched.push_back(f);
    end
    if (with_crc) begin
      f.kind = F_CRC; f.dqs = 2; f.crc = 1'b0;
      sched.push_back(f);
    end
    for (int k = 0; k < q; k++) begin
      f.kind = F_POST; f.crc = 1'b0;
      f.dqs = (k >= 2) ? 0 : ((c.post_pat >> (2 * (qe - 1 - k))) & 3);
      sched.push_back(f);
    end
  endtask

  task automatic model_edge();
    bit busy, take, done, consumed;
    err_exp = 1'b0;
    if (!enable) begin
      sched.delete();
      pend = 1'b0;
    end else begin
      busy = (sched.size() > 0);
      take = wr_en && busy;
      if (busy) void'(sched.pop_front());
      done = busy;
      foreach (sched[i]) if (sched[i].kind != F_POST) done = 1'b0;
      consumed = 1'b0;
      if (done && (pend || take)) begin
        consumed = 1'b1;
        if (pend) launch(pend_cfg); else launch(live());
      end else if (!busy && wr_en) begin
        launch(live());
      end
      if (take) begin
        if (consumed) begin
          if (pend) pend_cfg = live();
        end else if (pend) begin
          err_exp = 1'b1;
        end else begin
          pend = 1'b1;
          pend_cfg = live();
        end
      end else if (consumed) begin
        pend = 1'b0;
      end
    end
    last_data = int'(wdata);
    last_dm   = int'(wdm);
    last_crc  = int'(crc_code);
  endtask

  task automatic check_outputs();
    frame_t f;
    int e_dq, e_dm, e_dqs, e_crcd;
    bit e_dqv, e_crce, e_req, e_busy;
    f.kind = -1; f.dqs = 0; f.crc = 1'b0;
    if (sched.size() > 0) f = sched[0];
    e_dq   = (f.kind == F_DATA) ? last_data : ((f.kind == F_CRC) ? last_crc : 0);
    e_dm   = (f.kind == F_DATA) ? last_dm : 0;
    e_dqv  = (f.kind == F_DATA) || (f.kind == F_CRC);
    e_crce = (f.kind == F_DATA) && f.crc;
    e_crcd = e_crce ? last_data : 0;
    e_busy = (sched.size() > 0);
    e_req  = (sched.size() > 1) && (sched[1].kind == F_DATA);
    e_dqs  = 0;
    for (int l = 0; l < NL; l++) e_dqs = e_dqs | (f.dqs << (2 * l));
    check_val("dq",        64'(o_DQ),         64'(e_dq));
    check_val("dm",        64'(o_DM),         64'(e_dm));
    check_val("dq_valid",  64'(o_DQ_valid),   64'(e_dqv));
    check_val("dqs",       64'(o_DQS),        64'(e_dqs));
    check_val("dqs_valid", 64'(o_DQS_valid),  64'(e_busy));
    check_val("crc_en",    64'(o_crc_enable), 64'(e_crce));
    check_val("crc_data",  64'(o_crc_data),   64'(e_crcd));
    check_val("data_req",  64'(o_data_req),   64'(e_req));
    check_val("busy",      64'(o_busy),       64'(e_busy));
    check_val("wr_err",    64'(o_wr_err),     64'(err_exp));
  endtask

  task automatic tick(input bit wr);
    wr_en = wr;
    wdata = 16'($urandom);
    wdm   = 2'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    wr_en = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    sched.delete();
    pend = 1'b0;
    err_exp = 1'b0;
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_kind(input int kind, input int limit, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick(1'b0);
      if (sched.size() > 0 && sched[0].kind == kind) found = 1'b1;
    end
    check_val(tag, 64'(found), 64'(1));
  endtask

  task automatic set_cfg(input int pre, input int post, input int bl, input int pp,
                         input int qp, input bit phy, input bit dram);
    precycle = 3'(pre); postcycle = 2'(post); blen = 2'(bl);
    pre_pat = 8'(pp); post_pat = 4'(qp); phy_crc = phy; dram_crc = dram;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0, 1'b0);
    wdata = '0; wdm = '0; crc_code = '0;
    #12;
    check_outputs();
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1'b0);

    // preamble 00,00,10,10 then 16 data beats
    set_cfg(4, 1, 0, 8'b0000_1010, 0, 1'b0, 1'b0);
    tick(1'b1);
    repeat (26) tick(1'b0);

    // CRC requested, BC8
    set_cfg(2, 1, 1, 8'h06, 4'h2, 1'b1, 1'b1);
    crc_code = 16'hA55A;
    tick(1'b1);
    repeat (18) tick(1'b0);
    set_cfg(2, 1, 0, 8'h06, 4'h2, 1'b0, 1'b0);

    // back-to-back, then a dropped third command
    tick(1'b1);
    repeat (5) tick(1'b0);
    set_cfg(1, 2, 1, 8'h01, 4'h9, 1'b0, 1'b0);
    tick(1'b1);
    repeat (3) tick(1'b0);
    set_cfg(3, 3, 2, 8'h3C, 4'h5, 1'b0, 1'b0);
    tick(1'b1);
    repeat (40) tick(1'b0);

    // postamble cut short by a new command
    set_cfg(1, 2, 1, 8'h02, 4'b0110, 1'b0, 1'b0);
    tick(1'b1);
    wait_kind(F_POST, 40, "wait_post");
    tick(1'b1);
    repeat (20) tick(1'b0);

    // reset in the middle of a burst
    set_cfg(2, 1, 0, 8'h0A, 4'h1, 1'b0, 1'b0);
    tick(1'b1);
    wait_kind(F_DATA, 20, "wait_data");
    repeat (5) tick(1'b0);
    mid_reset();
    tick(1'b1);
    repeat (28) tick(1'b0);

    // enable drop during preamble discards the pending command
    set_cfg(4, 1, 0, 8'hA5, 4'h3, 1'b0, 1'b0);
    tick(1'b1);
    tick(1'b1);
    enable = 1'b0;
    tick(1'b0);
    tick(1'b1);
    enable = 1'b1;
    repeat (8) tick(1'b0);

    for (int c = 0; c < 700; c++) begin
      enable = ($urandom_range(0, 39) != 0);
      set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom));
      crc_code = 16'($urandom);
      tick($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
